// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: steps a 3-to-8 decoder select with blank/dwell enable timing.
// Optional DECODER_SCAN_HOLD_EN adds a hold input that freezes the dwell.
module decoder_scan_ctrl #(
  parameter int DWELL     = 4,
  parameter int BLANK     = 1,
  parameter int LAST_ADDR = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
`ifdef DECODER_SCAN_HOLD_EN
  input  logic       hold,
`endif
  output logic [2:0] a,
  output logic       e,
  output logic       busy,
  output logic       pass_done
);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;
  localparam logic [7:0] DW_M1 = 8'(DWELL - 1);
  localparam logic [7:0] BL_M1 = 8'(BLANK - 1);
  localparam logic [2:0] LAST  = 3'(LAST_ADDR);
  localparam state_t     FIRST = (BLANK == 0) ? S_DWELL : S_BLANK;
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] a_n;
  logic       e_n, busy_n, pd_n, cont_q, cq_n, stop_pend, sp_n;
  logic       hold_w, last_a, dwell_end, stop_eff;
`ifdef DECODER_SCAN_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif
  assign last_a    = a == LAST;
  assign dwell_end = state == S_DWELL && !hold_w && cnt == DW_M1;
  // a stop arriving on the final dwell cycle still ends the scan at that dwell
  assign stop_eff  = stop_pend | stop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a         <= '0;
      e         <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      a         <= a_n;
      e         <= e_n;
      busy      <= busy_n;
      pass_done <= pd_n;
      cont_q    <= cq_n;
      stop_pend <= sp_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? FIRST : S_IDLE;
      S_BLANK: state_n = (cnt == BL_M1) ? S_DWELL : S_BLANK;
      S_DWELL: state_n = !dwell_end ? S_DWELL :
                         (stop_eff || (last_a && !cont_q)) ? S_IDLE : FIRST;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    cnt_n  = (state == S_IDLE || state_n != state || dwell_end) ? 8'd0 :
             (state == S_DWELL && hold_w) ? cnt : cnt + 8'd1;
    a_n    = (state_n == S_IDLE) ? 3'd0 : dwell_end ? (last_a ? 3'd0 : a + 3'd1) : a;
    e_n    = state_n == S_DWELL;
    busy_n = state_n != S_IDLE;
    pd_n   = dwell_end && last_a;
    cq_n   = (state == S_IDLE && start) ? cont : cont_q;
    sp_n   = (state_n == S_IDLE) ? 1'b0 : stop_pend | (stop && state != S_IDLE);
  end
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed self-checking bench for decoder_scan_ctrl.
module tb_decoder_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, stop = 1'b0, hold = 1'b0;
  logic       start0 = 1'b0, stop0 = 1'b0;
  logic [2:0] a, a0;
  logic       e, busy, pass_done, e0, busy0, pd0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
`ifdef DECODER_SCAN_HOLD_EN
    .hold(hold),
`endif
    .a(a), .e(e), .busy(busy), .pass_done(pass_done)
  );

  // boundary build: single address, no blank gap, short dwell
  decoder_scan_ctrl #(.DWELL(2), .BLANK(0), .LAST_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont), .stop(stop0),
`ifdef DECODER_SCAN_HOLD_EN
    .hold(1'b0),
`endif
    .a(a0), .e(e0), .busy(busy0), .pass_done(pd0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {busy,e,a,pass_done} k edges after start acceptance, DWELL=4 BLANK=1 LAST_ADDR=7
  function automatic logic [5:0] model(input int k, input logic c);
    int m;
    m = k % 40;
    return {(c || k < 40), (k % 5) != 0, 3'(m / 5), (m == 0 && k > 0)};
  endfunction

  task automatic scan(input string tag, input int n, input logic c, input int sk);
    for (int k = 1; k <= n; k++) begin
      start = (k == sk);
      tick;
      chk(tag, {busy, e, a, pass_done}, model(k, c));
    end
    start = 1'b0;
  endtask

  task automatic go(input logic c, input logic stp);
    cont = c; start = 1'b1; stop = stp;
    tick;
    start = 1'b0; stop = 1'b0; cont = 1'b0;
    chk("go", {busy, e, a, pass_done}, 6'b100000);
  endtask

  initial begin
    int n, eh, pdk;
    #3 chk("reset", {busy, e, a, pass_done}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick;
    chk("idle", {busy, e, a, pass_done}, 6'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_in_idle", {busy, e, a, pass_done}, 6'b0);
    go(1'b0, 1'b0);
    scan("single_pass", 40, 1'b0, 0);
    tick;
    chk("pd_drop", {busy, e, a, pass_done}, 6'b0);
    go(1'b1, 1'b0);
    scan("continuous", 100, 1'b1, 0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick;
      n++;
    end
    chk("cont_stop", {busy, e, a, pass_done}, 6'b0);
    go(1'b1, 1'b0);
    scan("pre_stop", 17, 1'b1, 0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_dwell3", {busy, e, a, pass_done}, {1'b1, 1'b1, 3'd3, 1'b0});
    tick;
    chk("stop_dwell4", {busy, e, a, pass_done}, {1'b1, 1'b1, 3'd3, 1'b0});
    tick;
    chk("stop_idle", {busy, e, a, pass_done}, 6'b0);
    tick;
    chk("stop_no_pd", {busy, e, a, pass_done}, 6'b0);
    go(1'b0, 1'b0);
    scan("start_busy", 40, 1'b0, 12);
    go(1'b0, 1'b1);
    scan("start_stop", 40, 1'b0, 40);
    tick;
    chk("reentry_start", {busy, e, a, pass_done}, 6'b0);
    go(1'b0, 1'b0);
    scan("pre_reset", 27, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy, e, a, pass_done}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick;
    chk("post_reset", {busy, e, a, pass_done}, 6'b0);
    start0 = 1'b1; cont = 1'b1;
    tick;
    start0 = 1'b0; cont = 1'b0;
    chk("b0_go", {busy0, e0, a0, pd0}, 6'b110000);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("b0_cont", {busy0, e0, a0, pd0}, {2'b11, 3'd0, (k % 2) == 0});
    end
    stop0 = 1'b1;
    tick;
    stop0 = 1'b0;
    chk("b0_stop_dwell", {busy0, e0, a0, pd0}, 6'b110000);
    tick;
    chk("b0_stop_pd", {busy0, e0, a0, pd0}, 6'b000001);
`ifdef DECODER_SCAN_HOLD_EN
    go(1'b0, 1'b0);
    eh = 0; pdk = 0;
    for (int k = 1; k <= 60 && pdk == 0; k++) begin
      hold = (k >= 12 && k <= 21);
      tick;
      if (e && a == 3'd2) eh++;
      if (pass_done) pdk = k;
    end
    hold = 1'b0;
    chk("hold_e_cycles", eh, 14);
    chk("hold_pass_len", pdk, 50);
`else
    eh = 0; pdk = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequencer that drives the select/enable inputs of a 3-to-8 decoder (a[2:0], e) for scanning (LED columns, keypad rows, bank selects).
- Steps a through 0..LAST_ADDR, holding e high for DWELL cycles per address.
- Inserts BLANK cycles with e low between addresses, giving break-before-make on the decoder's one-hot output.
- Supports single-pass or continuous mode, with graceful stop.

Parameters:
- DWELL, 4, cycles e is high per address; legal 1..255
- BLANK, 1, cycles e is low before each address's dwell; legal 0..255
- LAST_ADDR, 7, final address of a pass; legal 0..7

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin scan; sampled only in IDLE
- cont  input  1  mode, latched when start is accepted; 1 = continuous, 0 = single pass
- stop  input  1  request end of scan; sampled only while busy
- a  output  3  decoder select, registered
- e  output  1  decoder enable, registered
- busy  output  1  high in any state other than IDLE
- pass_done  output  1  one-cycle pulse at the end of each complete pass

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; a=0, e=0, busy=0, pass_done=0; counters, cont_q and stop_pend cleared. Release is synchronous to the next clk edge.
- States: IDLE, BLANK, DWELL. An 8-bit cycle counter is shared by BLANK and DWELL.
- IDLE:
  - e=0, a=0.
  - start=1: latch cont into cont_q, set a=0, busy=1.
  - Next state is BLANK, or DWELL directly if BLANK=0.
- BLANK:
  - e=0, a stable; lasts exactly BLANK cycles, then DWELL.
- DWELL:
  - e=1, a stable; lasts exactly DWELL cycles.
  - Address period is BLANK+DWELL cycles. Pass length is (LAST_ADDR+1)*(BLANK+DWELL) cycles.
- End of a DWELL:
  - If stop_pend=1: go to IDLE (a=0, e=0, busy=0). pass_done pulses only if a==LAST_ADDR.
  - Else if a≠LAST_ADDR: a←a+1, go to BLANK (or DWELL if BLANK=0).
  - Else (a==LAST_ADDR): pass_done=1 for one cycle, aligned with the first cycle after the final dwell cycle.
    - cont_q=1: a←0, go to BLANK/DWELL.
    - cont_q=0: go to IDLE.
- Output timing:
  - a changes only on the edge that enters BLANK, or enters DWELL when BLANK=0.
  - With BLANK≥1, a never changes while e=1.
  - With BLANK=0, e stays high across address changes; this is permitted.
- stop:
  - A stop pulse while busy sets stop_pend, which is held until IDLE.
  - The current address's dwell always completes and is never truncated.
  - stop during BLANK still completes that address's dwell.
  - stop in IDLE is ignored.
- start:
  - start while busy is ignored.
  - start and stop high together in IDLE: start accepted, stop ignored.
  - start high on the same cycle IDLE is re-entered is ignored. A new scan needs start sampled in IDLE.
- LAST_ADDR=0: the scan dwells on address 0 only, and pass_done fires every BLANK+DWELL cycles in continuous mode.
- Reset mid-scan forces the reset values immediately. No pass_done is generated.

Optional Feature:
- Macro: DECODER_SCAN_HOLD_EN.
- Defined:
  - Adds input hold (1 bit).
  - While hold=1 in DWELL, the counter freezes and a and e hold their values (e stays 1). This extends the dwell with no limit.
  - hold has no effect in IDLE or BLANK.
  - A stop_pend set during hold takes effect when the dwell completes after hold drops.
- Not defined: no hold port; dwell is always exactly DWELL cycles.

Test Plan:
- Reset, then DWELL=4, BLANK=1, cont=0, start pulse:
  - a steps 0..7 with e high 4 cycles per address and low 1 cycle before each.
  - pass_done pulses once, 40 cycles after start is accepted.
  - busy then drops, a=0.
- cont=1, start, run 100 cycles:
  - pass_done pulses at cycles 40 and 80.
  - a wraps 7→0 with a 1-cycle e gap; busy stays 1.
- cont=1, stop pulsed during the 2nd dwell cycle of a=3:
  - e stays high for 2 more cycles, then IDLE (a=0, e=0, busy=0).
  - No pass_done.
- start while busy, and start+stop together in IDLE: the first is ignored; the second starts a scan with stop ignored.
- rst_n low during the dwell of a=5: a=0, e=0, busy=0 immediately, before the next edge. After release, the block stays IDLE until start.
- DECODER_SCAN_HOLD_EN: hold=1 for 10 cycles during the dwell of a=2. e stays high for 14 cycles total at a=2, and the pass completes in 50 cycles.
